// File: rtl/branch_tag_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_tag_allocator_if
// Description : Dispatch/resolve/allocation bundle for the branch tag
//               allocator.
//               The allocator side uses the "slave" modport. The dispatch,
//               CDB and checkpoint side uses the "master" modport.
// Signals     : dispatch_branch        - dispatching instr needs a checkpoint
//               resolve_valid          - a branch resolves this cycle
//               resolve_tag            - one-hot tag of the resolving branch
//               resolve_mispredict     - resolving branch mispredicted
//               resolve_dep_mask       - older-branch mask of that branch
//               alloc_grant            - tag allocated this cycle
//               alloc_tag              - one-hot allocated tag (0 if none)
//               checkpoint_write       - checkpoint array write enable
//               checkpoint_branch_mask - checkpoint array slot select
//               dispatch_dep_mask      - branches the dispatcher depends on
//               stall                  - dispatch_branch refused this cycle
//               full                   - every slot busy
//               inflight_count         - number of busy slots
//               illegal_resolve        - sticky protocol error flag
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_tag_allocator_if #(
  parameter int BS_SIZE = 4
);
  localparam int CNT_W = $clog2(BS_SIZE + 1);

  logic               dispatch_branch;
  logic               resolve_valid;
  logic [BS_SIZE-1:0] resolve_tag;
  logic               resolve_mispredict;
  logic [BS_SIZE-1:0] resolve_dep_mask;

  logic               alloc_grant;
  logic [BS_SIZE-1:0] alloc_tag;
  logic               checkpoint_write;
  logic [BS_SIZE-1:0] checkpoint_branch_mask;
  logic [BS_SIZE-1:0] dispatch_dep_mask;
  logic               stall;
  logic               full;
  logic [CNT_W-1:0]   inflight_count;
  logic               illegal_resolve;

  // Allocator side
  modport slave (
    input  dispatch_branch,
    input  resolve_valid,
    input  resolve_tag,
    input  resolve_mispredict,
    input  resolve_dep_mask,
    output alloc_grant,
    output alloc_tag,
    output checkpoint_write,
    output checkpoint_branch_mask,
    output dispatch_dep_mask,
    output stall,
    output full,
    output inflight_count,
    output illegal_resolve
  );

  // Dispatch / CDB / checkpoint side
  modport master (
    output dispatch_branch,
    output resolve_valid,
    output resolve_tag,
    output resolve_mispredict,
    output resolve_dep_mask,
    input  alloc_grant,
    input  alloc_tag,
    input  checkpoint_write,
    input  checkpoint_branch_mask,
    input  dispatch_dep_mask,
    input  stall,
    input  full,
    input  inflight_count,
    input  illegal_resolve
  );
endinterface
`default_nettype wire

// File: rtl/branch_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : branch_tag_allocator
// Description : Allocates one-hot branch tags at dispatch. Tracks every
//               unresolved in-flight branch in a busy vector. Frees a tag on
//               correct resolution. On a mispredict, frees the mispredicted
//               branch and all younger branches.
// Ports       : clock - system clock
//               reset - synchronous reset, active-high
//               bus   - branch_tag_allocator_if.slave. It carries the dispatch
//                       request, the CDB resolve fields, the allocation and
//                       checkpoint outputs, and the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_tag_allocator #(
  parameter int BS_SIZE = 4
) (
  input  wire logic              clock,
  input  wire logic              reset,
  branch_tag_allocator_if.slave  bus
);

  localparam int                 CNT_W = $clog2(BS_SIZE + 1);
  localparam logic [BS_SIZE-1:0] ONE   = {{(BS_SIZE-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [BS_SIZE-1:0] busy_q;
  logic [BS_SIZE-1:0] busy_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               illegal_q;
  logic               illegal_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               squash;
  logic               full;
  logic [BS_SIZE-1:0] free_mask;
  logic [BS_SIZE-1:0] lowest_free;
  logic               grant;
  logic [BS_SIZE-1:0] alloc_tag;
  logic [BS_SIZE-1:0] resolve_clr;
  logic               tag_onehot;
  logic               tag_not_busy;
  logic               dep_has_tag;
  logic               illegal_event;

  assign squash = bus.resolve_valid & bus.resolve_mispredict;
  assign full   = &busy_q;

  // Isolate the lowest set bit of the free mask. This is the lowest-index clear
  // busy bit. The search uses only the registered busy value, so a slot freed
  // this cycle cannot be handed out again until the next cycle.
  assign free_mask   = ~busy_q;
  assign lowest_free = free_mask & (~free_mask + ONE);

  // Reset gating keeps a grant from appearing during the reset cycle, when
  // busy_q still holds stale tags.
  assign grant     = bus.dispatch_branch & ~full & ~squash & ~reset;
  assign alloc_tag = grant ? lowest_free : '0;

  assign resolve_clr = bus.resolve_valid ? bus.resolve_tag : '0;

  // Protocol checks on the resolve fields
  assign tag_onehot    = (bus.resolve_tag != '0) &&
                         ((bus.resolve_tag & (bus.resolve_tag - ONE)) == '0);
  assign tag_not_busy  = (bus.resolve_tag & busy_q) == '0;
  assign dep_has_tag   = (bus.resolve_dep_mask & bus.resolve_tag) != '0;
  assign illegal_event = (bus.resolve_valid & (~tag_onehot | tag_not_busy)) |
                         (squash & dep_has_tag);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (squash) begin
      // The dependence mask lists only branches older than the mispredicted
      // one. Keeping just those bits frees that branch and everything younger.
      busy_d = bus.resolve_dep_mask & busy_q;
    end else begin
      busy_d = (busy_q & ~resolve_clr) | alloc_tag;
    end
  end

  // Keep the counter consistent with busy by construction instead of
  // tracking increments and decrements separately.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < BS_SIZE; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  assign illegal_d = illegal_q | illegal_event;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.alloc_grant            = grant;
  assign bus.alloc_tag              = alloc_tag;
  assign bus.checkpoint_write       = grant;
  assign bus.checkpoint_branch_mask = alloc_tag;
  assign bus.dispatch_dep_mask      = busy_q;
  assign bus.stall                  = bus.dispatch_branch & (full | squash);
  assign bus.full                   = full;
  assign bus.inflight_count         = count_q;
  assign bus.illegal_resolve        = illegal_q;

endmodule
`default_nettype wire

// File: doc/branch_tag_allocator.md
Name: branch_tag_allocator

Overview:
- Allocates one-hot branch tags (branch stack slots) at dispatch and tracks every in-flight unresolved branch.
- Drives the checkpoint-write request and index into the branch-stack checkpoint array.
- Supplies each dispatched instruction with its dependence mask.
- Frees tags on correct resolution; on a mispredict squash it frees the mispredicted branch and all younger branches.

Parameters:
BS_SIZE, 4, number of branch stack slots (tag width, one-hot)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
dispatch_branch  in  1  dispatching instruction is a branch/JALR needing a checkpoint
resolve_valid  in  1  a branch resolves this cycle (CDB)
resolve_tag  in  BS_SIZE  one-hot tag of the resolving branch
resolve_mispredict  in  1  resolving branch mispredicted (squash)
resolve_dep_mask  in  BS_SIZE  dependence mask carried by the mispredicted branch (older branches)
alloc_grant  out  1  tag allocated this cycle
alloc_tag  out  BS_SIZE  one-hot allocated tag (0 when no grant)
checkpoint_write  out  1  equals alloc_grant
checkpoint_branch_mask  out  BS_SIZE  equals alloc_tag
dispatch_dep_mask  out  BS_SIZE  branches the dispatching instruction depends on (= busy register)
stall  out  1  dispatch_branch refused this cycle
full  out  1  all slots busy
inflight_count  out  $clog2(BS_SIZE+1)  number of busy slots
illegal_resolve  out  1  sticky error flag

Behaviour:
- State: busy[BS_SIZE] register, inflight_count register, illegal_resolve sticky register.
- Reset: busy=0, inflight_count=0, illegal_resolve=0. Outputs after reset: full=0, dispatch_dep_mask=0, alloc_grant=0, alloc_tag=0, stall=0.
- Reset mid-operation discards all tags; no grant is issued during the reset cycle.
- squash = resolve_valid & resolve_mispredict.
- Allocation is combinational from the registered busy value:
  - Selected slot is the lowest-index clear bit of busy.
  - alloc_grant = dispatch_branch & ~full & ~squash.
  - alloc_tag is the one-hot selected slot when granted, else 0.
- stall = dispatch_branch & (full | squash).
- A bit freed this cycle is not reusable until the next cycle.
- full = &busy. dispatch_dep_mask = busy (registered, zero latency).
- Next-state priority, highest first:
  1. squash: busy_next = resolve_dep_mask & busy.
     - The mispredicted tag and all younger tags are freed.
     - Any allocation is suppressed in the squash cycle.
  2. Otherwise:
     - busy_next = (busy & ~(resolve_valid ? resolve_tag : 0)) | alloc_tag.
     - Correct resolution and allocation in the same cycle are both applied.
- inflight_count_next = popcount(busy_next).
- illegal_resolve is set and held until reset when any of these occurs:
  - resolve_valid with resolve_tag not one-hot;
  - resolve_valid with resolve_tag not in busy;
  - squash with resolve_dep_mask containing resolve_tag.
  - In all three cases the busy update still applies as specified.
- Latency: a granted tag appears in busy and dispatch_dep_mask on the next cycle.
- Full boundary: with BS_SIZE tags busy, a correct resolve in cycle N lets dispatch be granted in cycle N+1, not N.
- Empty boundary: a resolve with busy=0 has no effect on busy and sets illegal_resolve.

Test Plan:
- After reset, dispatch_branch=1 for 4 cycles → alloc_tag 0001, 0010, 0100, 1000; then full=1, inflight_count=4; 5th request → stall=1, alloc_grant=0.
- busy=1111, resolve_valid=1, resolve_tag=0010, mispredict=0, dispatch_branch=1 → stall that cycle, busy=1101; next cycle alloc_tag=0010, busy=1111.
- busy=0111, squash with resolve_tag=0010, resolve_dep_mask=0001, dispatch_branch=1 → alloc_grant=0, stall=1; next cycle busy=0001, inflight_count=1, dispatch_dep_mask=0001.
- busy=0011, resolve_tag=0001 correct, dispatch_branch=1 in the same cycle → alloc_tag=0100, busy_next=0110, checkpoint_write=1, checkpoint_branch_mask=0100.
- busy=0001, resolve_valid with resolve_tag=0100 → illegal_resolve=1 and sticky, busy unchanged=0001; assert reset → illegal_resolve=0, busy=0.
- Reset asserted while busy=1011 and dispatch_branch=1 → no grant that cycle; next cycle busy=0, full=0, inflight_count=0.
